// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: request size encodings, responder FSM state encoding,
// latency counter width and a helper that maps the reserved size code
// onto a word access.
package dmem_pkg;

  // Request size encodings (2'b11 is reserved and behaves as a word).
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Latency counter width; covers LATENCY-1 for LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Collapse the reserved size code onto a word access.
  function automatic logic [1:0] effSize(input logic [1:0] size);
    if ((size == SZ_BYTE) || (size == SZ_HALF)) begin
      return size;
    end else begin
      return SZ_WORD;
    end
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory responder.
// Ports:
//   size       in  2   request size (byte/half/word, 11 treated as word)
//   addrLo     in  2   byte lane of the request
//   isUnsigned in  1   zero-extend loads when 1, sign-extend when 0
//   wdata      in  32  right-justified store data
//   rword      in  32  word read from the array
//   byteEn     out 4   lanes written by a store
//   storeWord  out 32  store data replicated onto the addressed lanes
//   loadData   out 32  selected and extended load data
//   misalign   out 1   access rejected as misaligned
// Build option: MISALIGN_TRAP_EN defined flags misaligned half/word
// accesses (no lanes enabled, load data 0); undefined aligns them down.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic        isUnsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [1:0]  offS;
  logic [31:0] shiftedS;
  logic        misalignS;

  // Misalignment detection for the trapping build; the other build never rejects.
  always_comb begin
    misalignS = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (effSize(size) == SZ_HALF) begin
      misalignS = addrLo[0];
    end else if (effSize(size) == SZ_WORD) begin
      misalignS = (addrLo != 2'b00);
    end else begin
      misalignS = 1'b0;
    end
`endif
  end

  // Lane offset (aligned down), byte enables, store replication and load extension.
  always_comb begin
    offS      = 2'b00;
    byteEn    = 4'b0000;
    storeWord = 32'h0000_0000;
    loadData  = 32'h0000_0000;
    shiftedS  = 32'h0000_0000;
    case (effSize(size))
      SZ_BYTE: begin
        offS      = addrLo;
        byteEn    = 4'b0001 << addrLo;
        storeWord = {4{wdata[7:0]}};
        shiftedS  = rword >> {offS, 3'b000};
        loadData  = isUnsigned ? {24'h00_0000, shiftedS[7:0]}
                               : {{24{shiftedS[7]}}, shiftedS[7:0]};
      end
      SZ_HALF: begin
        offS      = {addrLo[1], 1'b0};
        byteEn    = addrLo[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{wdata[15:0]}};
        shiftedS  = rword >> {offS, 3'b000};
        loadData  = isUnsigned ? {16'h0000, shiftedS[15:0]}
                               : {{16{shiftedS[15]}}, shiftedS[15:0]};
      end
      default: begin
        offS      = 2'b00;
        byteEn    = 4'b1111;
        storeWord = wdata;
        shiftedS  = rword;
        loadData  = rword;
      end
    endcase
    // A rejected access must neither write nor return data.
    if (misalignS) begin
      byteEn   = 4'b0000;
      loadData = 32'h0000_0000;
    end else begin
      byteEn   = byteEn;
      loadData = loadData;
    end
  end

  assign misalign = misalignS;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor data port. Accepts one
// load/store at a time, waits LATENCY cycles, commits stores with lane
// masking and returns sign/zero-extended load data.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_addr, req_size,   store flag, byte address, size code,
//   req_unsigned, req_wdata       load extension mode, store data
//   resp_valid/resp_ready         response handshake (held until consumed)
//   resp_rdata, resp_err          extended load data, misalign error
// Build option: MISALIGN_TRAP_EN enables trapping of misaligned accesses
// (see dmem_lane_align); undefined, such accesses are aligned down.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t              stateR, nextStateS;
  logic [CNT_W-1:0]    cntR;
  logic                weR, unsR;
  logic [ADDR_W+1:0]   addrR;
  logic [1:0]          sizeR;
  logic [31:0]         wdataR;
  logic                reqReadyR, respValidR, respErrR;
  logic [31:0]         respRdataR;
  logic                acceptS, commitS;
  logic [ADDR_W-1:0]   idxS;
  logic [31:0]         rwordS, storeWordS, loadDataS;
  logic [3:0]          byteEnS;
  logic                misalignS;
  logic [31:0]         memArr [DEPTH_WORDS];
  logic                unusedAddrBits;

  // Upper address bits only alias the array, so they are dropped at capture.
  assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

  assign idxS   = addrR[ADDR_W+1:2];
  assign rwordS = memArr[idxS];

  dmem_lane_align uAlign (
    .size       (sizeR),
    .addrLo     (addrR[1:0]),
    .isUnsigned (unsR),
    .wdata      (wdataR),
    .rword      (rwordS),
    .byteEn     (byteEnS),
    .storeWord  (storeWordS),
    .loadData   (loadDataS),
    .misalign   (misalignS)
  );

  // Next-state decode plus accept/commit strobes.
  always_comb begin
    nextStateS = stateR;
    acceptS    = 1'b0;
    commitS    = 1'b0;
    case (stateR)
      ST_IDLE: begin
        if (req_valid && reqReadyR) begin
          nextStateS = ST_WAIT;
          acceptS    = 1'b1;
        end else begin
          nextStateS = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cntR == CNT_LAST) begin
          nextStateS = ST_RESP;
          commitS    = 1'b1;
        end else begin
          nextStateS = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (respValidR && resp_ready) begin
          nextStateS = ST_IDLE;
        end else begin
          nextStateS = ST_RESP;
        end
      end
      default: nextStateS = ST_IDLE;
    endcase
  end

  // State, handshake flags and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR     <= ST_IDLE;
      reqReadyR  <= 1'b0;
      respValidR <= 1'b0;
      cntR       <= '0;
    end else begin
      stateR     <= nextStateS;
      reqReadyR  <= (nextStateS == ST_IDLE);
      respValidR <= (nextStateS == ST_RESP);
      if (acceptS) begin
        cntR <= '0;
      end else if ((stateR == ST_WAIT) && !commitS) begin
        cntR <= cntR + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Request capture at accept; fields are ignored outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weR    <= 1'b0;
      unsR   <= 1'b0;
      addrR  <= '0;
      sizeR  <= 2'b00;
      wdataR <= 32'h0000_0000;
    end else if (acceptS) begin
      weR    <= req_we;
      unsR   <= req_unsigned;
      addrR  <= req_addr[ADDR_W+1:0];
      sizeR  <= req_size;
      wdataR <= req_wdata;
    end
  end

  // Response data/error registered on the WAIT->RESP edge, stable through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      respRdataR <= 32'h0000_0000;
      respErrR   <= 1'b0;
    end else if (commitS) begin
      respRdataR <= weR ? 32'h0000_0000 : loadDataS;
      respErrR   <= misalignS;
    end
  end

  // Array write on the commit edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (commitS && weR && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEnS[b]) begin
          memArr[idxS][8*b +: 8] <= storeWordS[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = reqReadyR;
  assign resp_valid = respValidR;
  assign resp_rdata = respRdataR;
  assign resp_err   = respErrR;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Expectations follow the MISALIGN_TRAP_EN setting of the build.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int AW      = 10;
  localparam int LAT     = 2;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int numChecks = 0;
  int numFails  = 0;

  logic [31:0] gotData;
  logic        gotErr;
  int          gotCycles;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    numChecks++;
    if (obs !== expd) begin
      numFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expd);
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic startReq(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_size = size; req_unsigned = uns; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (w >= TIMEOUT) checkVal("acceptTimeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
  endtask

  // Wait for resp_valid; cycles counts negedges after the accept edge.
  task automatic waitResp(output logic [31:0] rdata, output logic err, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!resp_valid && cycles < TIMEOUT);
    rdata = resp_rdata;
    err   = resp_err;
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doStore(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
    startReq(1'b1, addr, size, 1'b0, wdata);
    waitResp(gotData, gotErr, gotCycles);
    checkVal({tag, "_rdata"}, gotData, 32'h0);
  endtask

  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] expd, input logic expErr);
    startReq(1'b0, addr, size, uns, 32'h0);
    waitResp(gotData, gotErr, gotCycles);
    checkVal(tag, gotData, expd);
    checkVal({tag, "_err"}, {31'd0, gotErr}, {31'd0, expErr});
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkVal("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkVal("rst_resp_rdata", resp_rdata, 32'h0);
    checkVal("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // 1. Reset during WAIT aborts the store
    doStore("pre10", 32'h10, SZ_WORD, 32'h0BAD_F00D);
    startReq(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    checkVal("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    checkVal("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkVal("midrst_resp_rdata", resp_rdata, 32'h0);
    checkVal("midrst_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    doLoad("ld10_after_rst", 32'h10, SZ_WORD, 1'b0, 32'h0BAD_F00D, 1'b0);

    // 2. Word store with latency check, then word load
    startReq(1'b1, 32'h20, SZ_WORD, 1'b0, 32'h1122_3344);
    waitResp(gotData, gotErr, gotCycles);
    checkVal("st20_latency", 32'(gotCycles), 32'(LAT + 1));
    checkVal("st20_rdata", gotData, 32'h0);
    startReq(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0);
    waitResp(gotData, gotErr, gotCycles);
    checkVal("ld20_latency", 32'(gotCycles), 32'(LAT + 1));
    checkVal("ld20_word", gotData, 32'h1122_3344);

    // 3. Byte store and byte loads
    doStore("stb21", 32'h21, SZ_BYTE, 32'h0000_00AA);
    doLoad("ldb21_signed", 32'h21, SZ_BYTE, 1'b0, 32'hFFFF_FFAA, 1'b0);
    doLoad("ldb21_unsigned", 32'h21, SZ_BYTE, 1'b1, 32'h0000_00AA, 1'b0);
    doLoad("ld20_after_byte", 32'h20, SZ_WORD, 1'b0, 32'h1122_AA44, 1'b0);
    doLoad("ldb20_signed", 32'h20, SZ_BYTE, 1'b0, 32'h0000_0044, 1'b0);

    // 4. Half store and half loads
    doStore("sth22", 32'h22, SZ_HALF, 32'h0000_8001);
    doLoad("ldh22_signed", 32'h22, SZ_HALF, 1'b0, 32'hFFFF_8001, 1'b0);
    doLoad("ldh22_unsigned", 32'h22, SZ_HALF, 1'b1, 32'h0000_8001, 1'b0);
    doLoad("ld20_after_half", 32'h20, SZ_WORD, 1'b0, 32'h8001_AA44, 1'b0);
    doLoad("ldres20", 32'h20, 2'b11, 1'b0, 32'h8001_AA44, 1'b0);

    // 5. Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    doLoad("ldw21_mis", 32'h21, SZ_WORD, 1'b0, 32'h0, 1'b1);
    doLoad("ldh23_mis", 32'h23, SZ_HALF, 1'b0, 32'h0, 1'b1);
    startReq(1'b1, 32'h22, SZ_WORD, 1'b0, 32'h5555_5555);
    waitResp(gotData, gotErr, gotCycles);
    checkVal("stw22_mis_err", {31'd0, gotErr}, 32'd1);
    checkVal("stw22_mis_latency", 32'(gotCycles), 32'(LAT + 1));
    doLoad("ld20_after_mis", 32'h20, SZ_WORD, 1'b0, 32'h8001_AA44, 1'b0);
`else
    doLoad("ldw21_mis", 32'h21, SZ_WORD, 1'b0, 32'h8001_AA44, 1'b0);
    doLoad("ldh23_mis", 32'h23, SZ_HALF, 1'b0, 32'hFFFF_8001, 1'b0);
    doLoad("ld20_after_mis", 32'h20, SZ_WORD, 1'b0, 32'h8001_AA44, 1'b0);
`endif

    // 6. Back-pressure on an aliased address, and aliased store
    resp_ready = 1'b0;
    startReq(1'b0, 32'h20 + 32'(4 * DEPTH), SZ_WORD, 1'b0, 32'h0);
    waitResp(gotData, gotErr, gotCycles);
    checkVal("alias_ld_data", gotData, 32'h8001_AA44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkVal("bp_resp_rdata", resp_rdata, 32'h8001_AA44);
      checkVal("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    doStore("alias_st", 32'h24 + 32'(4 * DEPTH), SZ_WORD, 32'hCAFE_F00D);
    doLoad("alias_ld24", 32'h24, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
